// File: rtl/cvp14_pkg.sv
// Shared definitions for the vector datapath: opcode constants, default
// widths for the vector register / memory interface, and the load/store
// sequencer state encoding.
package cvp14_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_VLD = 4'b0100;
  localparam logic [3:0] OP_VST = 4'b0101;

  localparam int NUM_ELEM_D = 16;
  localparam int DATA_W_D   = 16;
  localparam int ADDR_W_D   = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/vls_pipe_stage.sv
// Two-deep shift register carrying {valid, element index, word} from the
// issue stage to the write stage of a vector load/store transfer.
// The word carried here is the element's memory address, so the store write
// stage gets base+k without recomputing it.
// Ports:
//   Clk1, Reset            clock, synchronous active-high reset
//   in_valid/in_idx/in_word  values being registered into the issue stage
//   out_valid/out_idx/out_word  same values two cycles later
module vls_pipe_stage #(
  parameter int IDX_W  = 4,
  parameter int WORD_W = 16
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic [WORD_W-1:0] out_word
);

  logic [2:1]             vld_pipe;
  logic [2:1][IDX_W-1:0]  idx_pipe;
  logic [2:1][WORD_W-1:0] word_pipe;

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      vld_pipe  <= '0;
      idx_pipe  <= '0;
      word_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[1], in_valid};
      idx_pipe  <= {idx_pipe[1], in_idx};
      word_pipe <= {word_pipe[1], in_word};
    end
  end

  assign out_valid = vld_pipe[2];
  assign out_idx   = idx_pipe[2];
  assign out_word  = word_pipe[2];

endmodule

// File: rtl/vls_sequencer.sv
// Vector load/store sequencer. Moves NUM_ELEM elements between the 16-bit
// memory bus and the vector register file's serial element port, one
// element per cycle, in a three-stage pipeline:
//   stage 1: issue read (RD for vld, vRD_s for vst) for element k
//   stage 2: read data returns and is sampled
//   stage 3: write (vWR_s for vld, WR for vst) of element k
// Ports:
//   Clk1, Reset                  clock, synchronous active-high reset
//   start/is_store/base_addr/vreg  request, sampled while busy=0
//   busy, done                   transfer in progress / completion pulse
//   Addr, RD, WR, DataOut, DataIn  memory bus
//   vAddr, vElem, vRD_s, vOutS, vWR_s, vInS  vector register serial port
// All outputs are registered; address/data outputs hold when their strobe
// is low.
module vls_sequencer
  import cvp14_pkg::*;
#(
  parameter int NUM_ELEM = NUM_ELEM_D,
  parameter int ADDR_W   = ADDR_W_D,
  parameter int DATA_W   = DATA_W_D,
  parameter int EIDX_W   = $clog2(NUM_ELEM)
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [2:0]        vreg,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] Addr,
  output logic              RD,
  output logic              WR,
  output logic [DATA_W-1:0] DataOut,
  input  logic [DATA_W-1:0] DataIn,
  output logic [2:0]        vAddr,
  output logic [EIDX_W-1:0] vElem,
  output logic              vRD_s,
  input  logic [DATA_W-1:0] vOutS,
  output logic              vWR_s,
  output logic [DATA_W-1:0] vInS
);

  localparam logic [EIDX_W-1:0] K_LAST = EIDX_W'(NUM_ELEM - 1);

  seq_state_e        state;
  logic              st_r;
  logic [2:0]        vreg_r;
  logic [EIDX_W-1:0] k;
  logic [ADDR_W-1:0] iaddr;
  logic              drain_cnt;

  // Issue-stage values for the next cycle. On acceptance they come straight
  // from the request inputs so cycle 1 issues element 0 without a bubble.
  logic              accept;
  logic              iss_v_nxt;
  logic              iss_st_nxt;
  logic [EIDX_W-1:0] k_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [2:0]        vreg_nxt;

  logic              p_valid;
  logic [EIDX_W-1:0] p_idx;
  logic [ADDR_W-1:0] p_addr;

  always_comb begin
    accept     = start && (state == S_IDLE || state == S_DONE);
    iss_v_nxt  = accept || (state == S_ISSUE && k != K_LAST);
    iss_st_nxt = accept ? is_store  : st_r;
    k_nxt      = accept ? '0        : k + 1'b1;
    addr_nxt   = accept ? base_addr : iaddr + 1'b1;
    vreg_nxt   = accept ? vreg      : vreg_r;
  end

  // The pipe sees element k as it enters the issue stage; its output is
  // valid during the data-return cycle, which is when stage 3 is loaded.
  vls_pipe_stage #(
    .IDX_W  (EIDX_W),
    .WORD_W (ADDR_W)
  ) u_pipe (
    .Clk1      (Clk1),
    .Reset     (Reset),
    .in_valid  (iss_v_nxt),
    .in_idx    (k_nxt),
    .in_word   (addr_nxt),
    .out_valid (p_valid),
    .out_idx   (p_idx),
    .out_word  (p_addr)
  );

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state     <= S_IDLE;
      st_r      <= 1'b0;
      vreg_r    <= '0;
      k         <= '0;
      iaddr     <= '0;
      drain_cnt <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Addr      <= '0;
      RD        <= 1'b0;
      WR        <= 1'b0;
      DataOut   <= '0;
      vAddr     <= '0;
      vElem     <= '0;
      vRD_s     <= 1'b0;
      vWR_s     <= 1'b0;
      vInS      <= '0;
    end else begin
      done <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state  <= S_ISSUE;
            busy   <= 1'b1;
            st_r   <= is_store;
            vreg_r <= vreg;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (k == K_LAST) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (iss_v_nxt) begin
        k     <= k_nxt;
        iaddr <= addr_nxt;
      end

      // Stage 1: read strobes and their addresses.
      RD    <= iss_v_nxt && !iss_st_nxt;
      vRD_s <= iss_v_nxt &&  iss_st_nxt;
      if (iss_v_nxt) begin
        if (iss_st_nxt) begin
          vAddr <= vreg_nxt;
          vElem <= k_nxt;
        end else begin
          Addr <= addr_nxt;
        end
      end

      // Stage 3: write strobes with the word returned this cycle. Stage 1
      // and stage 3 of one transfer never touch the same output, and two
      // transfers never overlap, so Addr/vAddr/vElem have one writer per edge.
      WR    <= p_valid &&  st_r;
      vWR_s <= p_valid && !st_r;
      if (p_valid) begin
        if (st_r) begin
          Addr    <= p_addr;
          DataOut <= vOutS;
        end else begin
          vAddr <= vreg_r;
          vElem <= p_idx;
          vInS  <= DataIn;
        end
      end
    end
  end

endmodule

// File: tb/tb_vls_sequencer.sv
module tb_vls_sequencer;
  localparam int N = 16;

  logic        Clk1 = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [15:0] base_addr = '0;
  logic [2:0]  vreg = '0;
  logic        busy, done, RD, WR, vRD_s, vWR_s;
  logic [15:0] Addr, DataOut, vInS;
  logic [15:0] DataIn = '0;
  logic [15:0] vOutS = '0;
  logic [2:0]  vAddr;
  logic [3:0]  vElem;

  vls_sequencer dut (
    .Clk1(Clk1), .Reset(Reset), .start(start), .is_store(is_store),
    .base_addr(base_addr), .vreg(vreg), .busy(busy), .done(done),
    .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn),
    .vAddr(vAddr), .vElem(vElem), .vRD_s(vRD_s), .vOutS(vOutS),
    .vWR_s(vWR_s), .vInS(vInS)
  );

  always #5 Clk1 = ~Clk1;

  int checks = 0;
  int errors = 0;

  // Environment: read-only memory pattern, recorded memory writes, and a
  // vector register file that answers serial reads and records writes.
  logic [15:0] vrf [8][N];
  logic [15:0] mem_wr [logic [15:0]];
  logic        rd_pend = 1'b0, vrd_pend = 1'b0;
  logic [15:0] rd_addr = '0;
  logic [2:0]  vrd_reg = '0;
  logic [3:0]  vrd_elem = '0;

  always @(negedge Clk1) begin
    rd_pend  = RD;
    rd_addr  = Addr;
    vrd_pend = vRD_s;
    vrd_reg  = vAddr;
    vrd_elem = vElem;
    if (WR === 1'b1) mem_wr[Addr] = DataOut;
    if (vWR_s === 1'b1) vrf[vAddr][vElem] = vInS;
  end

  always @(posedge Clk1) begin
    #1;
    DataIn = rd_pend  ? (rd_addr ^ 16'hA5A5)       : 16'h0BAD;
    vOutS  = vrd_pend ? vrf[vrd_reg][vrd_elem]      : 16'h0BAD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transfer, checked cycle by cycle (t = cycles after acceptance).
  // Caller sits at a negedge; with launch=0 the request was already raised
  // by the previous transfer's done cycle.
  task automatic xfer(input logic st, input logic [15:0] base, input logic [2:0] vr,
                      input bit launch, input bit glitch, input int rst_at,
                      input bit chain, input logic nst, input logic [15:0] nbase,
                      input logic [2:0] nvr);
    logic [15:0] snap [N];
    logic [15:0] ea;
    for (int k = 0; k < N; k++) snap[k] = vrf[vr][k];
    if (st) mem_wr.delete();
    if (launch) begin
      start = 1'b1; is_store = st; base_addr = base; vreg = vr;
    end
    for (int t = 1; t <= N + 3; t++) begin
      @(negedge Clk1);
      if (t == 1) begin
        start = 1'b0; is_store = ~st; base_addr = 16'($urandom); vreg = 3'($urandom);
      end
      chk("busy",  busy,  t <= N + 2);
      chk("done",  done,  t == N + 3);
      chk("RD",    RD,    !st && t <= N);
      chk("WR",    WR,    st && t >= 3 && t <= N + 2);
      chk("vRD_s", vRD_s, st && t <= N);
      chk("vWR_s", vWR_s, !st && t >= 3 && t <= N + 2);
      if (!st) begin
        ea = (t <= N) ? base + 16'(t - 1) : base + 16'(N - 1);
        chk("ld_addr", Addr, ea);
        if (t >= 3 && t <= N + 2) begin
          ea = base + 16'(t - 3);
          chk("ld_velem", vElem, t - 3);
          chk("ld_vaddr", vAddr, vr);
          chk("ld_vins",  vInS,  ea ^ 16'hA5A5);
        end
      end else begin
        if (t <= N) begin
          chk("st_velem", vElem, t - 1);
          chk("st_vaddr", vAddr, vr);
        end
        if (t >= 3 && t <= N + 2) begin
          ea = base + 16'(t - 3);
          chk("st_addr",    Addr,    ea);
          chk("st_dataout", DataOut, snap[t - 3]);
        end
      end
      if (glitch && t == 5) begin
        start = 1'b1; is_store = ~st; base_addr = ~base; vreg = ~vr;
      end
      if (glitch && t == 6) start = 1'b0;
      if (rst_at == t) begin
        Reset = 1'b1;
        @(negedge Clk1);
        Reset = 1'b0;
        chk("rst_WR",    WR,    1'b0);
        chk("rst_RD",    RD,    1'b0);
        chk("rst_vRD_s", vRD_s, 1'b0);
        chk("rst_vWR_s", vWR_s, 1'b0);
        chk("rst_busy",  busy,  1'b0);
        for (int i = 0; i < 20; i++) begin
          @(negedge Clk1);
          chk("rst_no_done", done, 1'b0);
        end
        return;
      end
      if (chain && t == N + 3) begin
        start = 1'b1; is_store = nst; base_addr = nbase; vreg = nvr;
      end
    end
    // Final image of the destination.
    for (int k = 0; k < N; k++) begin
      ea = base + 16'(k);
      if (!st) chk("vrf_image", vrf[vr][k], ea ^ 16'hA5A5);
      else     chk("mem_image", mem_wr[ea], snap[k]);
    end
  endtask

  initial begin
    logic        rst_st;
    logic [15:0] rb;
    logic [2:0]  rv;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < N; k++) vrf[r][k] = '0;

    // Reset state.
    repeat (3) @(negedge Clk1);
    chk("rst_busy", busy, 0);  chk("rst_done", done, 0);
    chk("rst_RD", RD, 0);      chk("rst_WR", WR, 0);
    chk("rst_vRD", vRD_s, 0);  chk("rst_vWR", vWR_s, 0);
    chk("rst_Addr", Addr, 0);  chk("rst_DataOut", DataOut, 0);
    chk("rst_vAddr", vAddr, 0); chk("rst_vElem", vElem, 0);
    chk("rst_vInS", vInS, 0);
    Reset = 1'b0;
    @(negedge Clk1);

    // Load with an ignored second start at cycle 5.
    xfer(1'b0, 16'h0100, 3'd3, 1, 1, 0, 0, 1'b0, 16'h0, 3'd0);
    @(negedge Clk1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Store from vreg 5, chained in its done cycle into a wrapping load.
    for (int k = 0; k < N; k++) vrf[5][k] = 16'h1000 + 16'(k);
    xfer(1'b1, 16'h2000, 3'd5, 1, 0, 0, 1, 1'b0, 16'hFFF8, 3'd1);
    xfer(1'b0, 16'hFFF8, 3'd1, 0, 0, 0, 0, 1'b0, 16'h0, 3'd0);
    @(negedge Clk1);

    // Randomized transfers.
    for (int i = 0; i < 6; i++) begin
      rst_st = 1'($urandom);
      rb     = 16'($urandom);
      rv     = 3'($urandom);
      if (rst_st) for (int k = 0; k < N; k++) vrf[rv][k] = 16'($urandom);
      xfer(rst_st, rb, rv, 1, 1'($urandom), 0, 0, 1'b0, 16'h0, 3'd0);
      @(negedge Clk1);
    end

    // Reset in cycle 8 of a store, then a fresh load.
    for (int k = 0; k < N; k++) vrf[6][k] = 16'($urandom);
    xfer(1'b1, 16'($urandom), 3'd6, 1, 0, 8, 0, 1'b0, 16'h0, 3'd0);
    @(negedge Clk1);
    xfer(1'b0, 16'($urandom), 3'd2, 1, 0, 0, 0, 1'b0, 16'h0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vls_sequencer.md
Name: vls_sequencer

Overview:
- Sequences vector load (vld) and vector store (vst) transfers between the single 16-bit memory bus and the vector register file's serial element port.
- Sits between the core's control FSM and the memory and vector-register datapath.
- Control FSM pulses start with the opcode kind, base address and vector register index. The sequencer owns the bus for the whole transfer and signals done.
- Transfers are pipelined: one element per cycle, addresses base+0 .. base+NUM_ELEM-1.

Parameters:
- NUM_ELEM, 16, elements per vector register.
- ADDR_W, 16, memory address width.
- DATA_W, 16, element and memory data width.
- EIDX_W, 4, element index width; equals clog2(NUM_ELEM).

Ports:
- Clk1  in  1  clock; all state updates on posedge Clk1
- Reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only while busy=0
- is_store  in  1  1=vst (vreg->memory), 0=vld (memory->vreg); sampled with start
- base_addr  in  ADDR_W  first memory address; sampled with start
- vreg  in  3  vector register index; sampled with start
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- Addr  out  ADDR_W  memory address
- RD  out  1  memory read strobe
- WR  out  1  memory write strobe
- DataOut  out  DATA_W  memory write data
- DataIn  in  DATA_W  memory read data, valid the cycle after RD
- vAddr  out  3  vector register select
- vElem  out  EIDX_W  element select
- vRD_s  out  1  serial element read strobe
- vOutS  in  DATA_W  element read data, valid the cycle after vRD_s
- vWR_s  out  1  serial element write strobe
- vInS  out  DATA_W  element write data

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, RD=0, WR=0, vRD_s=0, vWR_s=0, Addr=0, DataOut=0, vAddr=0, vElem=0, vInS=0. State=IDLE.
- Reset has priority over everything. Reset asserted mid-transfer aborts it:
  - strobes are low after that edge;
  - no done pulse is issued;
  - partially written vreg or memory contents are left as-is.
- States:
  - IDLE: wait for start.
  - ISSUE: k=0..NUM_ELEM-1, one per cycle.
  - DRAIN: two cycles to flush the pipeline.
  - DONE: one cycle.
- Transfer timing (cycle 0 = cycle in which start is sampled high in IDLE):
  - Cycles 1..NUM_ELEM+2: busy=1.
  - Cycle NUM_ELEM+3: done=1, busy=0, state returns to IDLE.
- vld stage 1: cycles 1..16 drive RD=1 and Addr=base+k.
- vld stage 2: DataIn is sampled at the end of cycles 2..17.
- vld stage 3: cycles 3..18 drive vWR_s=1, vAddr=vreg, vElem=k, vInS=the sampled word.
- vst stage 1: cycles 1..16 drive vRD_s=1, vAddr=vreg, vElem=k.
- vst stage 2: vOutS is sampled at the end of cycles 2..17.
- vst stage 3: cycles 3..18 drive WR=1, Addr=base+k, DataOut=the sampled word.
- Mutual exclusion: RD and WR are never high in the same cycle; vRD_s and vWR_s are never high in the same cycle.
- Strobe-off values: when a strobe is low its associated address/data outputs hold their last value.
- Address arithmetic is modulo 2^ADDR_W: base 0xFFF8 wraps to 0x0000 after 0xFFFF.
- Element counter runs 0..NUM_ELEM-1 and does not wrap within a transfer.
- start is ignored while busy=1.
- start is accepted in the DONE cycle, since busy=0 there. In that case the next transfer's cycle 1 immediately follows, with no idle gap.
- base_addr, vreg and is_store are latched at acceptance. Later changes to them do not affect an in-flight transfer.
- Total latency: start to done = NUM_ELEM+3 cycles. Throughput is 1 element/cycle.

Decomposition:
- Shared package cvp14_pkg holds:
  - opcode constants, including vld=4'b0100 and vst=4'b0101;
  - the NUM_ELEM/DATA_W/ADDR_W defaults;
  - the sequencer state encoding IDLE/ISSUE/DRAIN/DONE.
- One natural sub-module: vls_pipe_stage, a 2-deep valid/data/index shift register that carries {valid, k, word} from the issue stage to the write stage. It is shared by load and store.

Test Plan:
- Load: memory model returns Addr^16'hA5A5; start, is_store=0, base_addr=16'h0100, vreg=3.
  - Expect RD at cycles 1..16 on Addr 0x0100..0x010F.
  - Expect vWR_s at cycles 3..18 with vElem=k and vInS=(0x0100+k)^0xA5A5.
  - Expect done at cycle 19.
- Store: vreg 5 preloaded with element k=16'h1000+k; start with is_store=1, base_addr=16'h2000.
  - Expect WR at cycles 3..18, Addr=0x2000+k, DataOut=0x1000+k.
  - Expect RD to stay 0 throughout.
- Wrap: load with base_addr=16'hFFF8 -> Addr sequence 0xFFF8..0xFFFF then 0x0000..0x0007.
- Busy ignore and back-to-back:
  - Second start at cycle 5 with different base is ignored.
  - A start asserted in the done cycle begins a new transfer, with RD high in the very next cycle.
- Reset mid-transfer: assert Reset at cycle 8 of a store.
  - The next cycle has WR=0, busy=0, and done never pulses.
  - A fresh load after reset completes correctly.
